// File: rtl/vec_mem_pkg.sv
// Shared types and constants for the vector load/store engine.
package vec_mem_pkg;

  // Engine sequencing states; the encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Transfer direction as carried on the mode input.
  localparam logic MODE_ST = 1'b0;  // vector register -> memory
  localparam logic MODE_LD = 1'b1;  // memory -> vector register

  // Width of a lane index; LANES is at least 2, so the result is at least 1.
  function automatic int lane_idx_w(input int lanes);
    return (lanes < 2) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/vec_mem_xfer_if.sv
// Bundle of issue-controller and memory-side signals for vec_mem_xfer.
//
// Handshake: the controller raises start for one cycle while busy is low and
// the engine is idle; operands (mode, base_addr, stride, lane_mask, vector_in)
// are sampled on that same edge only. busy rises the next cycle and stays high
// through the cycle in which done pulses; any start seen while busy is high is
// dropped, not queued. Memory side: a write commits on the edge where wr=1,
// and mem_rd_data must carry the word one cycle after the cycle with rd=1.
interface vec_mem_xfer_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16
);

  // Controller / memory -> engine
  logic                    start;
  logic                    mode;
  logic [ADDR_W-1:0]       base_addr;
  logic [ADDR_W-1:0]       stride;
  logic [LANES-1:0]        lane_mask;
  logic [LANES*DATA_W-1:0] vector_in;
  logic [DATA_W-1:0]       mem_rd_data;

  // Engine -> controller / memory
  logic [ADDR_W-1:0]       addr;
  logic                    wr;
  logic                    rd;
  logic [DATA_W-1:0]       mem_wr_data;
  logic [LANES*DATA_W-1:0] vector_out;
  logic                    busy;
  logic                    done;
  vec_mem_pkg::state_t     state;

  modport master (
    output start, mode, base_addr, stride, lane_mask, vector_in, mem_rd_data,
    input  addr, wr, rd, mem_wr_data, vector_out, busy, done, state
  );

  modport slave (
    input  start, mode, base_addr, stride, lane_mask, vector_in, mem_rd_data,
    output addr, wr, rd, mem_wr_data, vector_out, busy, done, state
  );

endinterface

// File: rtl/vec_lane_addr_gen.sv
// Lane address accumulator: base on load, base + k*stride after k steps,
// built from a single adder instead of a multiplier. Wraps silently.
module vec_lane_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr
);

  // Accumulated address; holds its value whenever neither load nor step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (step) begin
      addr <= addr + stride;
    end
  end

endmodule

// File: rtl/vec_mem_xfer.sv
// Vector load/store engine: moves one vector register to or from memory,
// one lane per cycle, with per-lane masking. All outputs are registered.
module vec_mem_xfer
  import vec_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  vec_mem_xfer_if.slave     bus
);

  localparam int            LW   = lane_idx_w(LANES);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  state_t                  state;
  logic [LW-1:0]           cnt;        // lane currently on the memory bus
  logic [LW-1:0]           nxt;
  logic                    mode_q;
  logic [ADDR_W-1:0]       stride_q;
  logic [LANES-1:0]        mask_q;
  logic [LANES*DATA_W-1:0] vec_q;
  logic                    wr_q;
  logic                    rd_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    cap_valid;
  logic [LW-1:0]           cap_lane;
  logic [LANES*DATA_W-1:0] vout_q;
  logic [ADDR_W-1:0]       addr_w;
  logic                    addr_load;
  logic                    addr_step;

  assign nxt       = cnt + LW'(1);
  assign addr_load = (state == IDLE) && bus.start;
  assign addr_step = (state == ISSUE) && (cnt != LAST);

  vec_lane_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (addr_load),
    .step   (addr_step),
    .base   (bus.base_addr),
    .stride (stride_q),
    .addr   (addr_w)
  );

  // Sequencer: lane 0 goes on the bus at the accepting edge, lane k+1 follows
  // lane k; the state names the phase the registered outputs are showing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_q   <= MODE_ST;
      stride_q <= '0;
      mask_q   <= '0;
      vec_q    <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q   <= bus.mode;
            stride_q <= bus.stride;
            mask_q   <= bus.lane_mask;
            vec_q    <= bus.vector_in;
            cnt      <= '0;
            busy_q   <= 1'b1;
            wr_q     <= (bus.mode == MODE_ST) && bus.lane_mask[0];
            rd_q     <= (bus.mode == MODE_LD) && bus.lane_mask[0];
            wdata_q  <= ((bus.mode == MODE_ST) && bus.lane_mask[0]) ?
                        bus.vector_in[DATA_W-1:0] : '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt != LAST) begin
            cnt     <= nxt;
            wr_q    <= (mode_q == MODE_ST) && mask_q[nxt];
            rd_q    <= (mode_q == MODE_LD) && mask_q[nxt];
            wdata_q <= ((mode_q == MODE_ST) && mask_q[nxt]) ?
                       vec_q[nxt*DATA_W +: DATA_W] : '0;
          end else begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            if (mode_q == MODE_LD) begin
              state <= DRAIN;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DRAIN: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load capture: remember which lane read last cycle, then write the returned
  // word into that lane; masked lanes never read, so they keep their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_lane  <= '0;
      vout_q    <= '0;
    end else begin
      cap_valid <= rd_q;
      cap_lane  <= cnt;
      if (cap_valid) begin
        vout_q[cap_lane*DATA_W +: DATA_W] <= bus.mem_rd_data;
      end
    end
  end

  assign bus.addr        = addr_w;
  assign bus.wr          = wr_q;
  assign bus.rd          = rd_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.vector_out  = vout_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_vec_mem_xfer.sv
// Directed bench for vec_mem_xfer with a behavioural single-port memory.
module tb_vec_mem_xfer;
  import vec_mem_pkg::*;

  localparam int DW = 16;
  localparam int NL = 16;
  localparam int AW = 16;
  localparam int VW = DW * NL;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_mem_xfer_if #(.DATA_W(DW), .LANES(NL), .ADDR_W(AW)) bus ();

  vec_mem_xfer #(.DATA_W(DW), .LANES(NL), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory: reads return one cycle after rd, writes commit on the wr edge.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.rd) bus.mem_rd_data <= mem[bus.addr];
    if (bus.wr) mem[bus.addr] = bus.mem_wr_data;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];  // {rd, wr, addr, wdata} per lane

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Raise start for one cycle; returns at the negedge where lane 0 is visible.
  task automatic issue(input logic m, input logic [AW-1:0] base, input logic [AW-1:0] strd,
                       input logic [NL-1:0] mask, input logic [VW-1:0] vec);
    @(negedge clk);
    bus.mode      = m;
    bus.base_addr = base;
    bus.stride    = strd;
    bus.lane_mask = mask;
    bus.vector_in = vec;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Disturb operands mid-transfer and pulse a start that must be dropped.
  task automatic disturb(input int k);
    if (k == 1) begin
      bus.vector_in = {8{$urandom()}};
      bus.base_addr = AW'($urandom_range(0, 65535));
      bus.stride    = AW'($urandom_range(3, 99));
      bus.lane_mask = ~bus.lane_mask;
      bus.mode      = ~bus.mode;
    end
    if (k == 3) bus.start = 1'b1;
    if (k == 4) bus.start = 1'b0;
  endtask

  // Check every lane of a store, then Done one cycle after the last lane.
  task automatic run_store(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] strd,
                           input logic [NL-1:0] mask, input logic [VW-1:0] vec);
    logic [AW-1:0] a;
    for (int k = 0; k < NL; k++) begin
      a = base + AW'(k) * strd;
      exp_q.push_back({1'b0, mask[k], a, mask[k] ? vec[k*DW +: DW] : 16'h0000});
    end
    for (int k = 0; k < NL; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("%s_lane%0d", tag, k),
          {bus.rd, bus.wr, bus.addr, bus.mem_wr_data}, exp_q.pop_front());
      disturb(k);
    end
    @(negedge clk);
    chk({tag, "_done"}, {bus.done, bus.busy, bus.wr, bus.rd}, 4'b1100);
    chk({tag, "_done_state"}, bus.state, DONE);
  endtask

  // Check every lane of a load, the DRAIN cycle, then Done with final data.
  task automatic run_load(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] strd,
                          input logic [NL-1:0] mask, input logic [VW-1:0] exp_vec);
    logic [AW-1:0] a;
    for (int k = 0; k < NL; k++) begin
      a = base + AW'(k) * strd;
      exp_q.push_back({mask[k], 1'b0, a, 16'h0000});
    end
    for (int k = 0; k < NL; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("%s_lane%0d", tag, k),
          {bus.rd, bus.wr, bus.addr, bus.mem_wr_data}, exp_q.pop_front());
      disturb(k);
    end
    @(negedge clk);
    chk({tag, "_drain"}, {bus.done, bus.busy, bus.rd, bus.wr}, 4'b0100);
    chk({tag, "_drain_state"}, bus.state, DRAIN);
    @(negedge clk);
    chk({tag, "_done"}, {bus.done, bus.busy}, 2'b11);
    chk({tag, "_vector_out"}, bus.vector_out, exp_vec);
  endtask

  // Watchdog: every wait is a fixed cycle count, this is only a backstop.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  logic [VW-1:0] vec_a, vec_c, vec_d, vec_5, exp_v;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = DW'(a);
    for (int k = 0; k < NL; k++) begin
      vec_a[k*DW +: DW] = 16'hA000 + DW'(k);
      vec_c[k*DW +: DW] = 16'hC000 + DW'(k);
      vec_d[k*DW +: DW] = 16'hD000 + DW'(k);
      vec_5[k*DW +: DW] = 16'h5555;
    end
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode = MODE_ST; bus.base_addr = '0; bus.stride = '0;
    bus.lane_mask = '0; bus.vector_in = '0; bus.mem_rd_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", {bus.addr, bus.wr, bus.rd, bus.mem_wr_data, bus.busy, bus.done}, '0);
    chk("reset_vector_out", bus.vector_out, '0);
    chk("reset_state", bus.state, IDLE);
    rst_n = 1'b1;

    // Store, contiguous, all lanes
    issue(MODE_ST, 16'h0100, 16'h0001, 16'hFFFF, vec_a);
    run_store("st_a", 16'h0100, 16'h0001, 16'hFFFF, vec_a);
    @(negedge clk);
    chk("st_a_idle", {bus.done, bus.busy, bus.wr}, 3'b000);
    chk("st_a_idle_state", bus.state, IDLE);
    chk("st_a_mem_first", mem[16'h0100], 16'hA000);
    chk("st_a_mem_last", mem[16'h010F], 16'hA00F);

    // Load, stride 2, all lanes: lane k = 0x0200 + 2k
    for (int k = 0; k < NL; k++) exp_v[k*DW +: DW] = 16'h0200 + DW'(2 * k);
    issue(MODE_LD, 16'h0200, 16'h0002, 16'hFFFF, '0);
    run_load("ld_b", 16'h0200, 16'h0002, 16'hFFFF, exp_v);

    // Back-to-back: store with address wrap issued the cycle after Done
    issue(MODE_ST, 16'hFFFE, 16'h0001, 16'hFFFF, vec_5);
    run_store("st_wrap", 16'hFFFE, 16'h0001, 16'hFFFF, vec_5);
    chk("st_wrap_mem_ffff", mem[16'hFFFF], 16'h5555);
    chk("st_wrap_mem_0000", mem[16'h0000], 16'h5555);

    // Preload every VectorOut lane with 0x5555 through a wrapping load
    issue(MODE_LD, 16'hFFFE, 16'h0001, 16'hFFFF, '0);
    run_load("ld_pre", 16'hFFFE, 16'h0001, 16'hFFFF, vec_5);

    // Masked store: only lanes 4..7 strobe
    issue(MODE_ST, 16'h0300, 16'h0001, 16'h00F0, vec_c);
    run_store("st_mask", 16'h0300, 16'h0001, 16'h00F0, vec_c);
    chk("st_mask_mem_3", mem[16'h0303], 16'h0303);
    chk("st_mask_mem_4", mem[16'h0304], 16'hC004);
    chk("st_mask_mem_8", mem[16'h0308], 16'h0308);

    // Masked load: only lanes 4..7 change, others keep 0x5555
    exp_v = vec_5;
    for (int k = 4; k < 8; k++) exp_v[k*DW +: DW] = 16'hC000 + DW'(k);
    issue(MODE_LD, 16'h0300, 16'h0001, 16'h00F0, '0);
    run_load("ld_mask", 16'h0300, 16'h0001, 16'h00F0, exp_v);

    // All-zero mask: no strobes, Done on time
    issue(MODE_ST, 16'h0500, 16'h0003, 16'h0000, vec_a);
    run_store("st_nomask", 16'h0500, 16'h0003, 16'h0000, vec_a);

    // Reset during lane 5 of a store
    issue(MODE_ST, 16'h0400, 16'h0001, 16'hFFFF, vec_d);
    repeat (5) @(negedge clk);
    chk("rst_mid_lane5", {bus.wr, bus.addr, bus.mem_wr_data}, {1'b1, 16'h0405, 16'hD005});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.addr, bus.wr, bus.rd, bus.mem_wr_data, bus.busy, bus.done}, '0);
    chk("rst_mid_vector_out", bus.vector_out, '0);
    chk("rst_mid_state", bus.state, IDLE);
    repeat (2) @(negedge clk);
    chk("rst_mid_mem_404", mem[16'h0404], 16'hD004);
    chk("rst_mid_mem_405", mem[16'h0405], 16'h0405);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_quiet%0d", i), {bus.wr, bus.busy, bus.done}, 3'b000);
    end
    chk("rst_quiet_mem_406", mem[16'h0406], 16'h0406);

    // Fresh start after reset runs from lane 0
    issue(MODE_ST, 16'h0400, 16'h0001, 16'hFFFF, vec_d);
    run_store("st_restart", 16'h0400, 16'h0001, 16'hFFFF, vec_d);
    chk("st_restart_mem_40f", mem[16'h040F], 16'hD00F);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_mem_xfer.md
# vec_mem_xfer

Parametrised vector load/store engine between the vector register file and the single-port data memory. On a start pulse it moves one full vector register (LANES words of DATA_W bits) to or from memory, one word per clock, at addresses Base + k·Stride. Per-lane masking is supported in both directions. Busy/done handshaking goes to the issue controller.

## Interface
- DATA_W, 16, bits per lane / memory word
- LANES, 16, lanes per vector register (≥2)
- ADDR_W, 16, memory address width
- Clk  in  1  single system clock, all logic on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle request; sampled only in IDLE
- Mode  in  1  0 = store (vector→memory), 1 = load (memory→vector)
- BaseAddr  in  ADDR_W  address of lane 0
- Stride  in  ADDR_W  unsigned address increment between lanes
- LaneMask  in  LANES  bit k=1 enables lane k
- VectorIn  in  LANES·DATA_W  store source; lane k = bits [k·DATA_W +: DATA_W]
- MemRdData  in  DATA_W  memory read data, valid the cycle after RD
- Addr  out  ADDR_W  memory address
- WR  out  1  memory write strobe
- RD  out  1  memory read strobe
- MemWrData  out  DATA_W  memory write data
- VectorOut  out  LANES·DATA_W  load result, same lane packing
- Busy  out  1  high from the cycle after accepted Start through the DONE state
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, DRAIN (load only), DONE.
- IDLE: when Start=1, latch Mode, BaseAddr, Stride, LaneMask, and VectorIn. Clear the lane counter and go to ISSUE.
- ISSUE, lane k = 0..LANES-1, one lane per cycle:
  - Addr = BaseAddr + k·Stride, mod 2^ADDR_W. Wrap-around is legal and silent.
  - Store: WR = LaneMask[k]; MemWrData = lane k when WR=1, else 0.
  - Load: RD = LaneMask[k].
  - Masked lanes still consume a cycle and advance the address.
- After lane LANES-1: a store goes to DONE; a load goes to DRAIN.
- Load capture: MemRdData is written into VectorOut lane k in the cycle after RD for lane k was issued. Masked lanes keep their previous VectorOut value. DRAIN captures the last lane.
- DONE: Done=1 for one cycle, then return to IDLE.
- Inputs are ignored while Busy=1:
  - Start is dropped, not queued.
  - Changes to input operands after Start do not affect the transfer in flight.
- WR and RD are never both high.
- Outside ISSUE: WR=0, RD=0, MemWrData=0, and Addr holds its last value.
- Reset, including in the middle of a transfer: immediately return to IDLE. Addr, WR, RD, MemWrData, VectorOut, Busy and Done all go to 0. No partial write completes after Rst_n falls.
- LaneMask all-zero: full-length transfer with no strobes; Done arrives at the normal time.

## Timing
- All outputs are registered.
- Start sampled high at edge 0. ISSUE lane k outputs are valid in cycle k+1.
- Store: Done is high in cycle LANES+1. Start-to-Done latency is LANES+1.
- Load: DRAIN is cycle LANES+1; Done is high in cycle LANES+2.
- VectorOut is final and stable when Done=1 and holds until the next load captures.
- Back-to-back: Start may be asserted in the cycle after Done (IDLE). Minimum issue interval is LANES+2 cycles for a store and LANES+3 for a load.
- Memory contract: a write commits on the edge where WR=1. Read data returns exactly 1 cycle after RD.

## Structure
- Package vec_mem_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the mode constants MODE_ST=0 and MODE_LD=1;
  - a lane-index width function, clog2(LANES).
- Sub-module vec_lane_addr_gen: an address accumulator.
  - Loads BaseAddr on start and adds Stride on each ISSUE cycle.
  - Removes the need for a multiplier.
- The top level holds the FSM, the lane counter, the store-side lane mux and the load-side lane demux/capture.

## Test plan
- Store, Base=0x0100, Stride=1, Mask=0xFFFF, lane k = 0xA000+k:
  - WR is high for 16 cycles, at Addr 0x0100..0x010F, with data 0xA000..0xA00F.
  - Done is high in cycle 17.
- Load, Base=0x0200, Stride=2, Mask=0xFFFF, memory[a] = a:
  - Lane k of VectorOut = 0x0200+2k.
  - Done is high in cycle 18.
- Store, Mask=0x00F0, VectorOut preloaded with 0x5555 in every lane:
  - Store: WR is high only for lanes 4–7; all other cycles have WR=0 and MemWrData=0.
  - Follow-up load with the same mask: only lanes 4–7 change; the other lanes stay 0x5555.
- Store, Base=0xFFFE, Stride=1:
  - Addr sequence is 0xFFFE, 0xFFFF, 0x0000, 0x0001, …; Done on time.
- Rst_n pulsed low during lane 5 of a store:
  - All outputs are 0 immediately; no further WR.
  - A new Start after release runs from lane 0.
- A second Start during Busy is ignored. A Start in the cycle after Done is accepted, and its latency is correct.
